bus_width_downsizer: RTL

Wide-to-narrow bus width adapter. Accepts one SIZE_IN-bit word under a valid/ready handshake and emits it as SIZE_IN/SIZE_OUT narrow beats under a second valid/ready handshake. It is the companion stage to the narrow-to-wide collector and sits on the return/transmit path toward narrow links (UART, byte-wide FIFOs). It supports full backpressure and sustains back-to-back words with no bubble between them.

---
 rtl/bus_adapter_pkg.sv | 21 ++
 rtl/bus_slice_mux.sv | 27 ++
 rtl/bus_width_downsizer.sv | 97 +++++++++
 3 files changed

// File: rtl/bus_adapter_pkg.sv
// Shared types and sizing helpers for the wide/narrow bus adapters.
// Used by both the downsizer and the narrow-to-wide collector.
package bus_adapter_pkg;

  typedef enum logic {
    EMPTY,
    BUSY
  } adapter_state_t;

  function automatic int beats(
    input int size_wide,
    input int size_narrow
  );
    return size_wide / size_narrow;
  endfunction

  function automatic int cnt_width(input int b);
    return (b <= 2) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/bus_slice_mux.sv
// Combinational narrow-slice select out of a wide word.
// Slice order follows BIG_ENDIAN (1: most significant slice at sel=0).
module bus_slice_mux
  import bus_adapter_pkg::*;
#(
  parameter int SIZE_IN    = 32,
  parameter int SIZE_OUT   = 8,
  parameter int BIG_ENDIAN = 1,
  parameter int BEATS      = beats(SIZE_IN, SIZE_OUT),
  parameter int CW         = cnt_width(BEATS)
) (
  input  logic [SIZE_IN-1:0]  word,
  input  logic [CW-1:0]       sel,
  output logic [SIZE_OUT-1:0] slice
);

  int idx;

  always_comb begin
    idx = int'(sel);
    if (BIG_ENDIAN != 0) begin
      idx = BEATS - 1 - int'(sel);
    end
    slice = SIZE_OUT'(word >> (idx * SIZE_OUT));
  end

endmodule

// File: rtl/bus_width_downsizer.sv
// Wide-to-narrow adapter: one SIZE_IN word out as SIZE_IN/SIZE_OUT beats.
// Optional last_out framing when BUS_WIDTH_DOWNSIZER_LAST_EN is defined.
module bus_width_downsizer
  import bus_adapter_pkg::*;
#(
  parameter int SIZE_IN    = 32,
  parameter int SIZE_OUT   = 8,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [SIZE_IN-1:0]  in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [SIZE_OUT-1:0] out
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
  ,
  output logic                last_out
`endif
);

  localparam int BEATS = beats(SIZE_IN, SIZE_OUT);
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (SIZE_IN % SIZE_OUT != 0) begin : g_bad_ratio
    $error("SIZE_IN must be a multiple of SIZE_OUT");
  end
  if (BEATS < 2) begin : g_bad_beats
    $error("need at least two beats per word");
  end

  adapter_state_t     state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SIZE_IN-1:0] hold_q;
  logic               in_xfer;
  logic               out_xfer;
  logic               at_last;

  // ready_out reaches ready_in combinationally so the next word
  // can load on the last beat without a bubble.
  always_comb begin
    at_last   = (cnt_q == LAST);
    valid_out = (state_q == BUSY);
    out_xfer  = valid_out && ready_out;
    ready_in  = !reset &&
                ((state_q == EMPTY) || (out_xfer && at_last));
    in_xfer   = valid_in && ready_in;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (in_xfer) begin
      state_d = BUSY;
      cnt_d   = '0;
    end else if (out_xfer) begin
      if (at_last) begin
        state_d = EMPTY;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      hold_q <= in;
    end
  end

  bus_slice_mux #(
    .SIZE_IN    (SIZE_IN),
    .SIZE_OUT   (SIZE_OUT),
    .BIG_ENDIAN (BIG_ENDIAN),
    .BEATS      (BEATS),
    .CW         (CW)
  ) u_mux (
    .word  (hold_q),
    .sel   (cnt_q),
    .slice (out)
  );

`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
  assign last_out = valid_out && at_last;
`endif

endmodule
